// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and helpers for the two-road phase sequencer.
package traffic_pkg;

    // Phase codes; these values appear on the phase output port.
    typedef enum logic [2:0] {
        EW_GREEN  = 3'd0,
        EW_YELLOW = 3'd1,
        RED_1     = 3'd2,
        NS_GREEN  = 3'd3,
        NS_YELLOW = 3'd4,
        RED_2     = 3'd5,
        FLASH     = 3'd6
    } phase_e;

    // Lamp vectors are {red, yellow, green}.
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    // Successor in the normal rotation; anything unexpected recovers to RED_2.
    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            RED_2:     n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = RED_1;
            RED_1:     n = NS_GREEN;
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = RED_2;
            default:   n = RED_2;
        endcase
        return n;
    endfunction

    // Double-dabble: 8-bit binary to three BCD digits {hundreds, tens, units}.
    function automatic logic [11:0] bin8_to_bcd(input logic [7:0] bin);
        logic [19:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            sh = sh << 1;
        end
        return sh[19:8];
    endfunction

endpackage

// File: rtl/ms_timebase.sv
// Restartable millisecond / second prescaler with a half-second toggle.
// Restart zeroes everything so a phase always starts on a clean boundary.
module ms_timebase
    import traffic_pkg::*;
#(
    parameter int CNT1MS   = 100000,
    parameter int MS_PER_S = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic tick_ms,
    output logic tick_s,
    output logic toggle,
    output logic tick_half
);

    localparam int PRE_W = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
    localparam int MS_W  = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CNT1MS - 1);
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_PER_S - 1);
    localparam logic [MS_W-1:0]  MS_HALF  = MS_W'((MS_PER_S > 1) ? (MS_PER_S / 2 - 1) : 0);

    logic [PRE_W-1:0] r_pre;
    logic [MS_W-1:0]  r_ms;
    logic             r_toggle;
    logic             w_tick_ms;

    assign w_tick_ms = (r_pre == PRE_LAST);
    assign tick_ms   = w_tick_ms;
    assign tick_s    = w_tick_ms && (r_ms == MS_LAST);
    // The toggle flips at the middle and at the end of every second.
    assign tick_half = w_tick_ms && ((r_ms == MS_HALF) || (r_ms == MS_LAST));
    assign toggle    = r_toggle;

    // Prescaler, ms counter and toggle; restart puts the toggle back to "on".
    always_ff @(posedge clk) begin
        if (!resetn || restart) begin
            r_pre    <= '0;
            r_ms     <= '0;
            r_toggle <= 1'b1;
        end else begin
            if (w_tick_ms) begin
                r_pre <= '0;
                r_ms  <= (r_ms == MS_LAST) ? '0 : r_ms + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            if (tick_half) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_seq.sv
// Two-road traffic phase sequencer: timed greens/yellows, all-red clearance,
// pedestrian green shortening and a flashing-yellow mode. All outputs registered.
module traffic_phase_seq
    import traffic_pkg::*;
#(
    parameter int CNT1MS     = 100000,
    parameter int MS_PER_S   = 1000,
    parameter int EW_GREEN_S = 4,
    parameter int NS_GREEN_S = 4,
    parameter int YELLOW_S   = 2,
    parameter int ALL_RED_MS = 500,
    parameter int PED_CUT_S  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ped_req,
    input  logic        flash_mode,
    output logic [2:0]  ew_light,
    output logic [2:0]  ns_light,
    output logic [2:0]  phase,
    output logic        phase_start,
    output logic [7:0]  remain_s,
    output logic [11:0] remain_bcd,
    output logic        ped_ack
);

    localparam logic [7:0]  EW_G_D   = 8'(EW_GREEN_S);
    localparam logic [7:0]  NS_G_D   = 8'(NS_GREEN_S);
    localparam logic [7:0]  YEL_D    = 8'(YELLOW_S);
    localparam logic [7:0]  PED_CUT  = 8'(PED_CUT_S);
    localparam logic [15:0] RED_LAST = 16'(ALL_RED_MS - 1);

    // Seconds loaded on entry; untimed phases show zero.
    function automatic logic [7:0] entry_secs(input phase_e p);
        logic [7:0] d;
        case (p)
            EW_GREEN:             d = EW_G_D;
            NS_GREEN:             d = NS_G_D;
            EW_YELLOW, NS_YELLOW: d = YEL_D;
            default:              d = 8'd0;
        endcase
        return d;
    endfunction

    phase_e      r_state;
    phase_e      w_state_next;
    logic        w_state_change;

    logic [15:0] r_red_ms;
    logic [15:0] w_red_ms_next;
    logic        r_ped_latch;
    logic        w_ped_latch_next;
    logic        w_ped_any;
    logic        w_ped_ack_next;
    logic        w_restart;
    logic [7:0]  w_remain_next;
    logic [11:0] w_bcd_next;
    logic [2:0]  w_ew_next;
    logic [2:0]  w_ns_next;
    logic        w_flash_on_next;

    logic [2:0]  r_ew;
    logic [2:0]  r_ns;
    logic [2:0]  r_phase;
    logic        r_phase_start;
    logic [7:0]  r_remain;
    logic [11:0] r_bcd;
    logic        r_ped_ack;

    logic        w_tick_ms;
    logic        w_tick_s;
    logic        w_toggle;
    logic        w_tick_half;

    ms_timebase #(
        .CNT1MS   (CNT1MS),
        .MS_PER_S (MS_PER_S)
    ) u_timebase (
        .clk       (clk),
        .resetn    (resetn),
        .restart   (w_restart),
        .tick_ms   (w_tick_ms),
        .tick_s    (w_tick_s),
        .toggle    (w_toggle),
        .tick_half (w_tick_half)
    );

    assign w_state_change = (w_state_next != r_state);
    // A request pulse in the current cycle is served as if already latched.
    assign w_ped_any      = r_ped_latch | ped_req;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= RED_2;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: flash request first, then phase expiry.
    always_comb begin
        w_state_next = r_state;
        if (flash_mode) begin
            w_state_next = FLASH;
        end else begin
            case (r_state)
                FLASH: w_state_next = RED_2;
                RED_1, RED_2: begin
                    if (w_tick_ms && (r_red_ms == RED_LAST)) begin
                        w_state_next = next_phase(r_state);
                    end
                end
                EW_GREEN, EW_YELLOW, NS_GREEN, NS_YELLOW: begin
                    if (w_tick_s && (r_remain == 8'd1)) begin
                        w_state_next = next_phase(r_state);
                    end
                end
                default: w_state_next = RED_2;
            endcase
        end
    end

    // Countdown, all-red counter, pedestrian latch/cut and timebase restart.
    always_comb begin
        w_remain_next    = r_remain;
        w_red_ms_next    = r_red_ms;
        w_ped_latch_next = w_ped_any;
        w_ped_ack_next   = 1'b0;
        w_restart        = w_state_change;
        if (w_state_change) begin
            // Expiry or flash wins over a pending cut; the latch carries over.
            w_remain_next = entry_secs(w_state_next);
            w_red_ms_next = 16'd0;
            if (w_state_next == FLASH) begin
                w_ped_latch_next = 1'b0;
            end
        end else begin
            case (r_state)
                FLASH: w_ped_latch_next = 1'b0;
                RED_1, RED_2: begin
                    if (w_tick_ms) begin
                        w_red_ms_next = r_red_ms + 16'd1;
                    end
                end
                EW_YELLOW, NS_YELLOW: begin
                    if (w_tick_s) begin
                        w_remain_next = r_remain - 8'd1;
                    end
                end
                EW_GREEN, NS_GREEN: begin
                    if (w_tick_s) begin
                        w_remain_next = r_remain - 8'd1;
                    end
                    if (w_ped_any) begin
                        w_ped_ack_next   = 1'b1;
                        w_ped_latch_next = 1'b0;
                        if (r_remain > PED_CUT) begin
                            w_remain_next = PED_CUT;
                            w_restart     = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Flash lamps follow the timebase toggle as it will be after this edge.
    assign w_flash_on_next = w_restart ? 1'b1 : (w_tick_half ? ~w_toggle : w_toggle);
    assign w_bcd_next      = bin8_to_bcd(w_remain_next);

    // Lamp decode for the upcoming phase.
    always_comb begin
        w_ew_next = LT_RED;
        w_ns_next = LT_RED;
        case (w_state_next)
            EW_GREEN:  w_ew_next = LT_GRN;
            EW_YELLOW: w_ew_next = LT_YEL;
            NS_GREEN:  w_ns_next = LT_GRN;
            NS_YELLOW: w_ns_next = LT_YEL;
            FLASH: begin
                w_ew_next = w_flash_on_next ? LT_YEL : LT_OFF;
                w_ns_next = w_flash_on_next ? LT_YEL : LT_OFF;
            end
            default: ;
        endcase
    end

    // Internal counters and pedestrian latch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_red_ms    <= 16'd0;
            r_ped_latch <= 1'b0;
        end else begin
            r_red_ms    <= w_red_ms_next;
            r_ped_latch <= w_ped_latch_next;
        end
    end

    // Output registers; phase_start is held high through reset so the
    // first cycle after release marks the start of RED_2.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ew          <= LT_RED;
            r_ns          <= LT_RED;
            r_phase       <= RED_2;
            r_phase_start <= 1'b1;
            r_remain      <= 8'd0;
            r_bcd         <= 12'd0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_ew          <= w_ew_next;
            r_ns          <= w_ns_next;
            r_phase       <= w_state_next;
            r_phase_start <= w_state_change;
            r_remain      <= w_remain_next;
            r_bcd         <= w_bcd_next;
            r_ped_ack     <= w_ped_ack_next;
        end
    end

    assign ew_light    = r_ew;
    assign ns_light    = r_ns;
    assign phase       = r_phase;
    assign phase_start = r_phase_start;
    assign remain_s    = r_remain;
    assign remain_bcd  = r_bcd;
    assign ped_ack     = r_ped_ack;

endmodule
